// File: rtl/jamma_joy_scan.sv
// JAMMA joystick scanner: time-multiplexes JSELECT over the player ports,
// settles, samples JJOY (merged with kb_joy for player 0) and debounces it.
// Ports: pclk, rst_n (async, active-low), en (scan enable),
//   JJOY/kb_joy (active-low inputs), JSELECT (player being driven),
//   joy_out (debounced active-low bits, player p at [p*JOY_W +: JOY_W]),
//   scan_done (one-cycle pulse after the last player's sample).
module jamma_joy_scan #(
  parameter int PLAYERS  = 2,
  parameter int JOY_W    = 8,
  parameter int SEL_W    = 2,
  parameter int SETTLE   = 1,
  parameter int DEBOUNCE = 3
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [JOY_W-1:0]         JJOY,
  input  logic [JOY_W-1:0]         kb_joy,
  output logic [SEL_W-1:0]         JSELECT,
  output logic [PLAYERS*JOY_W-1:0] joy_out,
  output logic                     scan_done
);

  localparam logic [3:0]       SET  = 4'(SETTLE);
  localparam logic [3:0]       DEB  = 4'(DEBOUNCE);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(PLAYERS - 1);

  logic [1:0]       rsync;
  logic             rst_i;
  logic [3:0]       cnt;
  logic [SEL_W-1:0] idx;
  logic             done;
  logic             sample_now;
  logic [JOY_W-1:0] smp;
  logic [JOY_W-1:0] cand [PLAYERS];
  logic [3:0]       stab [PLAYERS];
  logic [JOY_W-1:0] jo   [PLAYERS];

  // Assert asynchronously, release on the second clock edge.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rsync <= 2'b00;
    end else begin
      rsync <= {rsync[0], 1'b1};
    end
  end

  assign rst_i = rsync[1];

  assign sample_now = en && (cnt == SET);
  // Keyboard bits are wired-AND into player 0 only.
  assign smp = (idx == '0) ? (JJOY & kb_joy) : JJOY;

  always_ff @(posedge pclk or negedge rst_i) begin
    if (!rst_i) begin
      cnt  <= '0;
      idx  <= '0;
      done <= 1'b0;
    end else if (en) begin
      done <= sample_now && (idx == LAST);
      if (sample_now) begin
        cnt <= '0;
        idx <= (idx == LAST) ? '0 : idx + SEL_W'(1);
      end else begin
        cnt <= cnt + 4'd1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  // Output follows the candidate one cycle after it has been seen
  // DEBOUNCE times in a row; reapplying while stable is harmless.
  always_ff @(posedge pclk or negedge rst_i) begin
    if (!rst_i) begin
      for (int p = 0; p < PLAYERS; p++) begin
        cand[p] <= '1;
        stab[p] <= '0;
        jo[p]   <= '1;
      end
    end else if (en) begin
      for (int p = 0; p < PLAYERS; p++) begin
        if (stab[p] == DEB) begin
          jo[p] <= cand[p];
        end
        if (sample_now && (idx == SEL_W'(p))) begin
          if (smp == cand[p]) begin
            stab[p] <= (stab[p] == DEB) ? DEB : stab[p] + 4'd1;
          end else begin
            cand[p] <= smp;
            stab[p] <= 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    joy_out = '1;
    for (int p = 0; p < PLAYERS; p++) begin
      joy_out[p*JOY_W +: JOY_W] = jo[p];
    end
  end

  assign JSELECT   = idx;
  assign scan_done = done;

endmodule
